// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared types and sizes for the TD4 program sequencer
package td4_pkg;

    localparam int TD4_ADDR_W      = 4;
    localparam int TD4_DATA_W      = 4;
    localparam int TD4_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } td4_seq_state_e;

endpackage

// File: rtl/td4_sync_edge.sv
// rtl/td4_sync_edge.sv - multi-flop pin synchronizer with level and rising-edge outputs
module td4_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;

    always_comb begin
        sync_d    = '0;
        sync_d[0] = pin_i;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/td4_prog_sequencer.sv
// rtl/td4_prog_sequencer.sv - arbitrates the TD4 program memory port between CPU fetch and pin programming
module td4_prog_sequencer
    import td4_pkg::*;
#(
    parameter int ADDR_W      = TD4_ADDR_W,
    parameter int DATA_W      = TD4_DATA_W,
    parameter int SYNC_STAGES = TD4_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              wr_strobe,
    input  logic [DATA_W-1:0] wr_opcode,
    input  logic [DATA_W-1:0] wr_imm,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              cpu_en,
    output logic              cpu_clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_opcode,
    output logic [DATA_W-1:0] mem_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] load_addr,
    output logic              load_full,
    output logic              busy
);

    td4_seq_state_e    state_q;
    logic [ADDR_W-1:0] load_addr_q;
    logic [ADDR_W-1:0] load_addr_d;
    logic              load_full_q;
    logic [DATA_W-1:0] opcode_q;
    logic [DATA_W-1:0] imm_q;
    logic              cpu_en_q;
    logic              cpu_clr_q;

    logic prog_s;
    logic strobe_rise;

    td4_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_prog (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (prog_mode),
        .level_o (prog_s),
        .rise_o  ()
    );

    td4_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_strobe (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (wr_strobe),
        .level_o (),
        .rise_o  (strobe_rise)
    );

    assign load_addr_d = load_addr_q + ADDR_W'(1);

    // Strobe edges seen outside LOAD are dropped on purpose: nothing is queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HALT;
            load_addr_q <= '0;
            load_full_q <= 1'b0;
            opcode_q    <= '0;
            imm_q       <= '0;
            cpu_en_q    <= 1'b0;
            cpu_clr_q   <= 1'b0;
        end else begin
            cpu_clr_q <= 1'b0;
            case (state_q)
                HALT: begin
                    if (prog_s) begin
                        state_q     <= LOAD;
                        load_addr_q <= '0;
                        load_full_q <= 1'b0;
                    end else begin
                        state_q   <= RUN;
                        cpu_clr_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (strobe_rise) begin
                        state_q  <= WRITE;
                        opcode_q <= wr_opcode;
                        imm_q    <= wr_imm;
                    end else if (!prog_s) begin
                        state_q <= HALT;
                    end
                end
                WRITE: begin
                    state_q     <= LOAD;
                    load_addr_q <= load_addr_d;
                    if (&load_addr_q) begin
                        load_full_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (prog_s) begin
                        state_q  <= HALT;
                        cpu_en_q <= 1'b0;
                    end else begin
                        cpu_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    assign mem_addr   = (state_q == RUN) ? cpu_pc : load_addr_q;
    assign mem_opcode = opcode_q;
    assign mem_imm    = imm_q;
    assign mem_we     = (state_q == WRITE);
    assign load_addr  = load_addr_q;
    assign load_full  = load_full_q;
    assign cpu_en     = cpu_en_q;
    assign cpu_clr    = cpu_clr_q;
    assign busy       = (state_q != RUN);

endmodule

// File: tb/tb_td4_prog_sequencer.sv
// tb/tb_td4_prog_sequencer.sv - self-checking bench for td4_prog_sequencer
module tb_td4_prog_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_mode = 1'b0;
    logic       wr_strobe = 1'b0;
    logic [3:0] wr_opcode = 4'd0;
    logic [3:0] wr_imm = 4'd0;
    logic [3:0] cpu_pc = 4'd5;
    logic       cpu_en;
    logic       cpu_clr;
    logic [3:0] mem_addr;
    logic [3:0] mem_opcode;
    logic [3:0] mem_imm;
    logic       mem_we;
    logic [3:0] load_addr;
    logic       load_full;
    logic       busy;

    td4_prog_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .prog_mode  (prog_mode),
        .wr_strobe  (wr_strobe),
        .wr_opcode  (wr_opcode),
        .wr_imm     (wr_imm),
        .cpu_pc     (cpu_pc),
        .cpu_en     (cpu_en),
        .cpu_clr    (cpu_clr),
        .mem_addr   (mem_addr),
        .mem_opcode (mem_opcode),
        .mem_imm    (mem_imm),
        .mem_we     (mem_we),
        .load_addr  (load_addr),
        .load_full  (load_full),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pin histories give what the synchronizers see; mode 0=halt 1=load 2=write 3=run.
    int m_mode = 0;
    int m_run = 0;
    int m_addr = 0;
    int m_full = 0;
    int m_op = 0;
    int m_imm = 0;
    bit m_valid = 0;
    bit p_h[2];
    bit s_h[3];
    bit m_ps, m_sr;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_mode = 0; m_run = 0; m_addr = 0; m_full = 0; m_op = 0; m_imm = 0;
            p_h[0] = 0; p_h[1] = 0; s_h[0] = 0; s_h[1] = 0; s_h[2] = 0;
        end else if (m_valid) begin
            m_ps = p_h[1];
            m_sr = s_h[1] && !s_h[2];
            if (m_mode == 0) begin
                if (m_ps) begin m_mode = 1; m_addr = 0; m_full = 0; end
                else begin m_mode = 3; m_run = 0; end
            end else if (m_mode == 1) begin
                if (m_sr) begin m_mode = 2; m_op = int'(wr_opcode); m_imm = int'(wr_imm); end
                else if (!m_ps) m_mode = 0;
            end else if (m_mode == 2) begin
                m_addr = m_addr + 1;
                if (m_addr == 16) begin m_addr = 0; m_full = 1; end
                m_mode = 1;
            end else begin
                if (m_ps) m_mode = 0;
                else m_run = m_run + 1;
            end
            p_h[1] = p_h[0]; p_h[0] = prog_mode;
            s_h[2] = s_h[1]; s_h[1] = s_h[0]; s_h[0] = wr_strobe;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", int'(busy), int'(m_mode != 3));
            chk("mem_we", int'(mem_we), int'(m_mode == 2));
            chk("cpu_en", int'(cpu_en), int'(m_mode == 3 && m_run > 0));
            chk("cpu_clr", int'(cpu_clr), int'(m_mode == 3 && m_run == 0));
            chk("load_addr", int'(load_addr), m_addr);
            chk("load_full", int'(load_full), m_full);
            chk("mem_addr", int'(mem_addr), (m_mode == 3) ? int'(cpu_pc) : m_addr);
            chk("mem_opcode", int'(mem_opcode), m_op);
            chk("mem_imm", int'(mem_imm), m_imm);
        end
    end

    int wlog_n = 0;
    int wl_addr[128];
    int wl_op[128];
    int wl_imm[128];

    always @(negedge clk) begin
        if (m_valid && mem_we === 1'b1 && wlog_n < 128) begin
            wl_addr[wlog_n] = int'(mem_addr);
            wl_op[wlog_n]   = int'(mem_opcode);
            wl_imm[wlog_n]  = int'(mem_imm);
            wlog_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_strobe(input logic [3:0] op, input logic [3:0] im);
        wr_opcode = op;
        wr_imm = im;
        tick(1);
        wr_strobe = 1'b1;
        tick(3);
        wr_strobe = 1'b0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bit found;

        // reset, then free-running CPU
        tick(3);
        chk("rst_busy", int'(busy), 1);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_en", int'(cpu_en), 0);
        chk("rst_clr", int'(cpu_clr), 0);
        chk("rst_addr", int'(mem_addr), 0);
        rst = 1'b0;
        tick(1);
        chk("run_clr1", int'(cpu_clr), 1);
        chk("run_en1", int'(cpu_en), 0);
        chk("run_pc", int'(mem_addr), 5);
        tick(1);
        chk("run_clr2", int'(cpu_clr), 0);
        chk("run_en2", int'(cpu_en), 1);
        tick(4);

        // three programmed words
        prog_mode = 1'b1;
        tick(6);
        chk("load_busy", int'(busy), 1);
        base = wlog_n;
        do_strobe(4'h3, 4'h1);
        do_strobe(4'hB, 4'h7);
        do_strobe(4'hF, 4'h0);
        chk("three_cnt", wlog_n - base, 3);
        chk("w0_addr", wl_addr[base], 0);
        chk("w0_op", wl_op[base], 3);
        chk("w0_imm", wl_imm[base], 1);
        chk("w1_addr", wl_addr[base+1], 1);
        chk("w1_op", wl_op[base+1], 11);
        chk("w1_imm", wl_imm[base+1], 7);
        chk("w2_addr", wl_addr[base+2], 2);
        chk("w2_op", wl_op[base+2], 15);
        chk("w2_imm", wl_imm[base+2], 0);
        chk("three_laddr", int'(load_addr), 3);
        prog_mode = 1'b0;
        tick(8);
        chk("resume_busy", int'(busy), 0);
        chk("resume_en", int'(cpu_en), 1);

        // wrap past 16 words
        prog_mode = 1'b1;
        tick(6);
        base = wlog_n;
        for (int i = 0; i < 17; i++) begin
            do_strobe(4'(i), ~4'(i));
            if (i == 14) begin
                chk("w15_full", int'(load_full), 0);
                chk("w15_laddr", int'(load_addr), 15);
            end
            if (i == 15) begin
                chk("w16_full", int'(load_full), 1);
                chk("w16_laddr", int'(load_addr), 0);
            end
        end
        chk("wrap_cnt", wlog_n - base, 17);
        chk("wrap_a15", wl_addr[base+15], 15);
        chk("wrap_a16", wl_addr[base+16], 0);
        chk("wrap_op16", wl_op[base+16], 0);
        chk("wrap_imm16", wl_imm[base+16], 15);
        chk("wrap_laddr", int'(load_addr), 1);
        chk("wrap_full", int'(load_full), 1);

        // strobes in RUN and a strobe held across LOAD entry write nothing
        prog_mode = 1'b0;
        tick(8);
        base = wlog_n;
        do_strobe(4'h1, 4'h2);
        do_strobe(4'h4, 4'h8);
        wr_strobe = 1'b1;
        prog_mode = 1'b1;
        tick(8);
        wr_strobe = 1'b0;
        tick(3);
        chk("stale_cnt", wlog_n - base, 0);
        chk("stale_full", int'(load_full), 0);
        do_strobe(4'h5, 4'hA);
        chk("fresh_cnt", wlog_n - base, 1);
        chk("fresh_addr", wl_addr[base], 0);
        chk("fresh_op", wl_op[base], 5);
        chk("fresh_imm", wl_imm[base], 10);

        // prog_mode drops in the same cycle as the strobe edge
        base = wlog_n;
        wr_opcode = 4'h6;
        wr_imm = 4'hC;
        tick(1);
        wr_strobe = 1'b1;
        prog_mode = 1'b0;
        tick(3);
        wr_strobe = 1'b0;
        tick(8);
        chk("race_cnt", wlog_n - base, 1);
        chk("race_addr", wl_addr[base], 1);
        chk("race_op", wl_op[base], 6);
        chk("race_imm", wl_imm[base], 12);
        chk("race_busy", int'(busy), 0);

        // reset in the middle of WRITE
        prog_mode = 1'b1;
        tick(6);
        wr_opcode = 4'h9;
        wr_imm = 4'h3;
        tick(1);
        wr_strobe = 1'b1;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(1);
            if (mem_we === 1'b1) found = 1;
        end
        chk("rstw_seen", int'(found), 1);
        rst = 1'b1;
        wr_strobe = 1'b0;
        tick(1);
        chk("rstw_we", int'(mem_we), 0);
        chk("rstw_laddr", int'(load_addr), 0);
        chk("rstw_busy", int'(busy), 1);
        chk("rstw_en", int'(cpu_en), 0);
        rst = 1'b0;
        prog_mode = 1'b0;
        tick(8);
        chk("final_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
